// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// fetch_stage_pkg : shared constants and interrupt FSM encoding for fetch
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

  typedef enum logic [1:0] {
    INT_RUN     = 2'd0,
    INT_PEND    = 2'd1,
    INT_HANDLER = 2'd2
  } int_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_int_ctrl.sv
// ============================================================================
// fetch_int_ctrl : interrupt synchroniser, RUN/PEND/HANDLER FSM and EPC
// Rev 1.0 -- used only when FETCH_INTERRUPT_EN is defined
// ============================================================================
`default_nettype none

module fetch_int_ctrl
  import fetch_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_irq,
  input  logic        i_eret,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_pc,
  output logic        o_take,
  output logic        o_ret,
  output logic [31:0] o_epc
);

  logic [1:0]  sync_q;
  int_state_e  state_q, state_d;
  logic [31:0] epc_q, epc_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= 2'b00;
      state_q <= INT_RUN;
      epc_q   <= 32'h0;
    end else begin
      sync_q  <= {sync_q[0], i_irq};
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  // A request seen in RUN may be taken in the same cycle it becomes visible.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    o_take  = 1'b0;
    o_ret   = 1'b0;
    case (state_q)
      INT_RUN, INT_PEND: begin
        if (state_q == INT_PEND || sync_q[1]) begin
          if (!i_stall && !i_redirect) begin
            o_take  = 1'b1;
            epc_d   = i_pc;
            state_d = INT_HANDLER;
          end else begin
            state_d = INT_PEND;
          end
        end
      end
      INT_HANDLER: begin
        if (i_eret) begin
          o_ret   = 1'b1;
          state_d = INT_RUN;
        end
      end
      default: state_d = INT_RUN;
    endcase
  end

  assign o_epc = epc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC, ROM addressing and IF/ID register with stall/flush/redirect
// Rev 1.0 -- optional interrupt entry/return under FETCH_INTERRUPT_EN
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
`ifdef FETCH_INTERRUPT_EN
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
`endif
  parameter int          ROM_AW     = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_pc_plus4,
  output logic              o_valid,
`ifdef FETCH_INTERRUPT_EN
  input  logic              i_external_interrupt,
  input  logic              i_eret,
  output logic [31:0]       o_epc,
`endif
  output logic              o_pc_oob
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic        take, ret;
  logic [31:0] epc;
  logic [31:0] exc_target;

`ifdef FETCH_INTERRUPT_EN
  fetch_int_ctrl u_int_ctrl (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_irq      (i_external_interrupt),
    .i_eret     (i_eret),
    .i_stall    (i_stall),
    .i_redirect (i_redirect),
    .i_pc       (pc_q),
    .o_take     (take),
    .o_ret      (ret),
    .o_epc      (epc)
  );
  assign o_epc      = epc;
  assign exc_target = word_align(EXC_VECTOR);
`else
  assign take       = 1'b0;
  assign ret        = 1'b0;
  assign epc        = 32'h0;
  assign exc_target = 32'h0;
`endif

  assign pc_plus4   = pc_q + 32'd4;
  assign o_rom_addr = pc_q[ROM_AW+1:2];
  assign o_pc_oob   = |pc_q[31:ROM_AW+2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Any change of flow discards the word fetched this cycle.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (take)            pc_d = exc_target;
    else if (ret)        pc_d = epc;
    else if (i_redirect) pc_d = word_align(i_redirect_pc);
    else if (!i_stall)   pc_d = pc_plus4;

    if (take || ret || i_redirect || i_flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!i_stall) begin
      instr_d = i_rom_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  assign o_instr    = instr_q;
  assign o_pc_plus4 = pc4_q;
  assign o_valid    = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed plus randomized checks of fetch_stage against a
// cycle-level behavioural model; interrupt checks under FETCH_INTERRUPT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect, irq, eret;
  logic [31:0] redirect_pc;
  logic [6:0]  rom_addr;
  logic [31:0] rom_data, instr, pc_plus4, epc;
  logic        valid, pc_oob;
  logic [31:0] rom [128];
  logic        chk_en;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_stage dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_stall              (stall),
    .i_flush              (flush),
    .i_redirect           (redirect),
    .i_redirect_pc        (redirect_pc),
    .o_rom_addr           (rom_addr),
    .i_rom_data           (rom_data),
    .o_instr              (instr),
    .o_pc_plus4           (pc_plus4),
    .o_valid              (valid),
`ifdef FETCH_INTERRUPT_EN
    .i_external_interrupt (irq),
    .i_eret               (eret),
    .o_epc                (epc),
`endif
    .o_pc_oob             (pc_oob)
  );

`ifndef FETCH_INTERRUPT_EN
  assign epc = 32'h0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural PC, IF/ID contents, handler mode.
  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid;
  int          m_mode;  // 0 running, 1 request pending, 2 in handler
  logic [1:0]  m_hist;  // request visible two edges after it is sampled

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_epc = 32'h0;
    m_valid = 1'b0; m_mode = 0; m_hist = 2'b00;
  endtask

  task automatic model_step();
    logic        seen, pend, take, ret;
    logic [31:0] nxt;
    if (!rst_n) return;
    seen = m_hist[1];
    m_hist = {m_hist[0], irq};
    pend = 1'b0; take = 1'b0; ret = 1'b0;
`ifdef FETCH_INTERRUPT_EN
    pend = (m_mode == 1) || (m_mode == 0 && seen);
    take = pend && !stall && !redirect;
    ret  = (m_mode == 2) && eret;
`endif
    if (take || ret || redirect || flush) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = rom[m_pc[8:2]]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end
    if (take)          nxt = 32'h180;
    else if (ret)      nxt = m_epc;
    else if (redirect) nxt = redirect_pc & 32'hFFFF_FFFC;
    else if (stall)    nxt = m_pc;
    else               nxt = m_pc + 32'd4;
    if (take)      begin m_epc = m_pc; m_mode = 2; end
    else if (ret)  m_mode = 0;
    else if (pend) m_mode = 1;
    m_pc = nxt;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rom_addr", {25'h0, rom_addr}, {25'h0, m_pc[8:2]});
      check("pc_oob", {31'h0, pc_oob}, {31'h0, |m_pc[31:9]});
      check("valid", {31'h0, valid}, {31'h0, m_valid});
      check("instr", instr, m_instr);
      if (m_valid) check("pc_plus4", pc_plus4, m_pc4);
`ifdef FETCH_INTERRUPT_EN
      check("epc", epc, m_epc);
`endif
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;
    rom[16] = 32'hC0DE_0016;
    rom[10] = 32'hC0DE_000A;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    irq = 1'b0; eret = 1'b0; redirect_pc = 32'h0;
    model_reset();
    chk_en = 1'b1;
    cycle(); cycle();
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_addr", {25'h0, rom_addr}, 32'h0);
    check("rst_epc", epc, 32'h0);

    rst_n = 1'b1;
    cycle();
    check("seq0_instr", instr, 32'h11); check("seq0_pc4", pc_plus4, 32'h4);
    check("seq0_valid", {31'h0, valid}, 32'h1);
    cycle();
    check("seq1_instr", instr, 32'h22); check("seq1_pc4", pc_plus4, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_instr", instr, 32'h22);
      check("stall_addr", {25'h0, rom_addr}, 32'h2);
    end
    stall = 1'b0;
    cycle();
    check("seq2_instr", instr, 32'h33); check("seq2_pc4", pc_plus4, 32'hC);
    cycle();
    check("seq3_instr", instr, 32'h44); check("seq3_pc4", pc_plus4, 32'h10);

    redirect = 1'b1; redirect_pc = 32'h43; stall = 1'b1;
    cycle();
    check("redir_addr", {25'h0, rom_addr}, 32'h10);
    check("redir_bubble", {31'h0, valid}, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    cycle();
    check("redir_instr", instr, 32'hC0DE_0016);

    redirect = 1'b1; redirect_pc = 32'h204;
    cycle();
    check("oob_flag", {31'h0, pc_oob}, 32'h1);
    check("oob_addr", {25'h0, rom_addr}, 32'h1);

    redirect_pc = 32'hFFFF_FFFF;
    cycle();
    check("top_addr", {25'h0, rom_addr}, 32'h7F);
    redirect = 1'b0;
    cycle();
    check("wrap_pc4", pc_plus4, 32'h0);
    check("wrap_addr", {25'h0, rom_addr}, 32'h0);

`ifdef FETCH_INTERRUPT_EN
    begin
      bit found;
      redirect = 1'b1; redirect_pc = 32'h20;
      cycle();
      redirect = 1'b0; irq = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 3 && !found; k++) begin
        cycle();
        if (rom_addr == 7'h60) found = 1'b1;
      end
      check("irq_latency", {31'h0, found}, 32'h1);
      check("irq_epc", epc, 32'h28);
      irq = 1'b0;
      cycle(); cycle();
      irq = 1'b1;
      cycle(); cycle(); cycle();
      irq = 1'b0;
      repeat (4) cycle();
      check("masked_epc", epc, 32'h28);
      eret = 1'b1;
      cycle();
      eret = 1'b0;
      check("eret_addr", {25'h0, rom_addr}, 32'hA);
      check("eret_bubble", {31'h0, valid}, 32'h0);
      cycle();
      check("eret_instr", instr, 32'hC0DE_000A);
      check("eret_pc4", pc_plus4, 32'h2C);
    end
`endif

    for (int n = 0; n < 3000; n++) begin
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 511);
      eret     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) irq = ~irq;
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        model_reset();
        cycle();
        check("midrst_valid", {31'h0, valid}, 32'h0);
        rst_n = 1'b1;
      end
      cycle();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
